// File: rtl/bnn_layer_sequencer.sv
// bnn_layer_sequencer
//   Control FSM for one binary-neural-network fully-connected layer pass.
//   Loads an image from an AXI-Stream into the input buffer, issues one
//   engine job per neuron, packs the 1-bit results 8 per byte (neuron 0 in
//   bit 0) and returns them on an output AXI-Stream, then pulses irq_done.
//
//   Optional build macro: BNN_SEQ_TIMEOUT_EN enables an engine watchdog in
//   WAIT (TIMEOUT_CYCLES). Without it WAIT waits indefinitely.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   cfg_wr_en/addr/data           register writes: 0x00 CTRL (bit0 start,
//                                 bit1 abort), 0x01 IMG_LEN, 0x02 NUM_NEU
//   s_axis_tdata/tvalid/tlast     image stream in, s_axis_tready out
//   buf_we/waddr/wdata            input-buffer write port
//   eng_start/eng_neuron          engine job request
//   eng_done/eng_result           engine job completion and result bit
//   m_axis_tdata/tvalid/tlast     packed result stream, m_axis_tready in
//   busy, irq_done, err           status
module bnn_layer_sequencer #(
  parameter int IMG_BYTES_MAX  = 784,
  parameter int ADDR_W         = 10,
  parameter int NEURON_MAX     = 256,
  parameter int NEU_W          = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_wr_en,
  input  logic [7:0]        cfg_wr_addr,
  input  logic [31:0]       cfg_wr_data,
  input  logic [7:0]        s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_waddr,
  output logic [7:0]        buf_wdata,
  output logic              eng_start,
  output logic [NEU_W-1:0]  eng_neuron,
  input  logic              eng_done,
  input  logic              eng_result,
  output logic [7:0]        m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic              busy,
  output logic              irq_done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_SEND, S_DONE
  } state_t;

  localparam logic [ADDR_W:0] IMG_MAX_L = (ADDR_W+1)'(IMG_BYTES_MAX);
  localparam logic [NEU_W:0]  NEU_MAX_L = (NEU_W+1)'(NEURON_MAX);

  state_t            state, state_nxt;
  logic [ADDR_W:0]   img_len;
  logic [NEU_W:0]    num_neu;
  logic [ADDR_W-1:0] beat;
  logic [NEU_W-1:0]  neu;
  logic [7:0]        pack;

  logic ctrl_wr, start_req, abort_req, cfg_ok;
  logic beat_last, neu_last, byte_full, timeout;

  assign ctrl_wr   = cfg_wr_en && (cfg_wr_addr == 8'h00);
  assign abort_req = ctrl_wr && cfg_wr_data[1];
  // Abort takes priority over a start carried in the same write.
  assign start_req = ctrl_wr && cfg_wr_data[0] && !cfg_wr_data[1];
  assign cfg_ok    = (img_len != '0) && (img_len <= IMG_MAX_L) &&
                     (num_neu != '0) && (num_neu <= NEU_MAX_L);
  assign beat_last = ({1'b0, beat} == img_len - (ADDR_W+1)'(1));
  assign neu_last  = ({1'b0, neu} == num_neu - (NEU_W+1)'(1));
  assign byte_full = (neu[2:0] == 3'd7);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    s_axis_tready = 1'b0;
    buf_we        = 1'b0;
    buf_waddr     = '0;
    buf_wdata     = '0;
    eng_start     = 1'b0;
    eng_neuron    = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    irq_done      = 1'b0;
    case (state)
      S_IDLE: if (start_req && cfg_ok) state_nxt = S_LOAD;
      S_LOAD: begin
        s_axis_tready = 1'b1;
        buf_we        = s_axis_tvalid;
        buf_waddr     = beat;
        buf_wdata     = s_axis_tdata;
        if (s_axis_tvalid && beat_last) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        eng_start  = 1'b1;
        eng_neuron = neu;
        state_nxt  = S_WAIT;
      end
      S_WAIT: begin
        eng_neuron = neu;
        if (eng_done)     state_nxt = (byte_full || neu_last) ? S_SEND : S_ISSUE;
        else if (timeout) state_nxt = S_IDLE;
      end
      S_SEND: begin
        m_axis_tvalid = 1'b1;
        // pack only ever holds bits of neurons already collected for this
        // byte, so bits above the last neuron are already zero.
        m_axis_tdata  = pack;
        m_axis_tlast  = neu_last;
        if (m_axis_tready) state_nxt = neu_last ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        irq_done  = !abort_req;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort_req) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      img_len <= IMG_MAX_L;
      num_neu <= (NEU_W+1)'(10);
      beat    <= '0;
      neu     <= '0;
      pack    <= '0;
      err     <= 1'b0;
    end else begin
      if (cfg_wr_en && state == S_IDLE) begin
        if (cfg_wr_addr == 8'h01) img_len <= cfg_wr_data[ADDR_W:0];
        if (cfg_wr_addr == 8'h02) num_neu <= cfg_wr_data[NEU_W:0];
      end
      // An abort freezes the datapath so err and counters are left as-is.
      if (!abort_req) begin
        case (state)
          S_IDLE: if (start_req) begin
            if (cfg_ok) begin
              err  <= 1'b0;
              beat <= '0;
              neu  <= '0;
              pack <= '0;
            end else begin
              err <= 1'b1;
            end
          end
          S_LOAD: if (s_axis_tvalid) begin
            beat <= beat + ADDR_W'(1);
            if (s_axis_tlast != beat_last) err <= 1'b1;
          end
          S_WAIT: begin
            if (eng_done) begin
              pack[neu[2:0]] <= eng_result;
              if (!(byte_full || neu_last)) neu <= neu + NEU_W'(1);
            end else if (timeout) begin
              err <= 1'b1;
            end
          end
          S_SEND: if (m_axis_tready) begin
            pack <= '0;
            if (!neu_last) neu <= neu + NEU_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

`ifdef BNN_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // Cleared whenever outside WAIT, so every entry to WAIT starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   tmo_cnt <= '0;
    else if (state != S_WAIT)  tmo_cnt <= '0;
    else if (!eng_done)        tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  assign timeout = (state == S_WAIT) && !eng_done &&
                   (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  logic unused_bits;
  assign unused_bits = ^cfg_wr_data[31:ADDR_W+1];
`else
  assign timeout = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{cfg_wr_data[31:ADDR_W+1], 1'(TIMEOUT_CYCLES)};
`endif

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// tb_bnn_layer_sequencer
//   Self-checking bench for bnn_layer_sequencer: a stub engine answering
//   3 cycles after each eng_start, scoreboards for buffer writes and result
//   bytes, a table of configuration vectors and hand-written corner cases.
module tb_bnn_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_wr_en;
  logic [7:0]  cfg_wr_addr;
  logic [31:0] cfg_wr_data;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic        buf_we;
  logic [9:0]  buf_waddr;
  logic [7:0]  buf_wdata;
  logic        eng_start;
  logic [7:0]  eng_neuron;
  logic        eng_done, eng_result;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic        busy, irq_done, err;

  bnn_layer_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
    .eng_start(eng_start), .eng_neuron(eng_neuron),
    .eng_done(eng_done), .eng_result(eng_result),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .busy(busy), .irq_done(irq_done), .err(err)
  );

  initial forever #5 clk = ~clk;

  typedef struct { logic [7:0] data; logic last; } obyte_t;
  typedef struct { logic [9:0] addr; logic [7:0] data; } bw_t;
  typedef struct { int len; int nn; logic exp_err; logic exp_busy; } cfg_vec_t;

  obyte_t out_q[$];
  bw_t    buf_q[$];
  logic   res [0:255];
  bit     eng_en = 1'b1;
  int     exp_neu = 0;
  int     irq_cnt = 0;
  int     errors = 0;
  int     checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard sinks and irq counter
  initial forever begin
    @(negedge clk);
    if (buf_we) begin
      if (buf_q.size() == 0) check("buf_unexpected_write", {buf_waddr, buf_wdata}, 64'hFFFF_FFFF);
      else begin
        bw_t e;
        e = buf_q.pop_front();
        check("buf_waddr", buf_waddr, e.addr);
        check("buf_wdata", buf_wdata, e.data);
      end
    end
    if (m_axis_tvalid && m_axis_tready) begin
      if (out_q.size() == 0) check("out_unexpected_byte", {m_axis_tdata, m_axis_tlast}, 64'hFFFF_FFFF);
      else begin
        obyte_t o;
        o = out_q.pop_front();
        check("out_tdata", m_axis_tdata, o.data);
        check("out_tlast", m_axis_tlast, o.last);
      end
    end
    if (irq_done) irq_cnt++;
  end

  // Stub engine: eng_done 3 cycles after each eng_start
  initial begin
    int n;
    eng_done = 1'b0;
    eng_result = 1'b0;
    forever begin
      @(negedge clk);
      if (eng_start && eng_en) begin
        check("eng_neuron", eng_neuron, exp_neu);
        n = int'(eng_neuron);
        exp_neu++;
        repeat (3) @(posedge clk);
        #1 eng_done = 1'b1;
        eng_result = res[n];
        @(posedge clk);
        #1 eng_done = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench watchdog expired");
  end

  task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk);
    #1 cfg_wr_en = 1'b1;
    cfg_wr_addr = a;
    cfg_wr_data = d;
    @(posedge clk);
    #1 cfg_wr_en = 1'b0;
    cfg_wr_addr = '0;
    cfg_wr_data = '0;
  endtask

  task automatic stream(input int len, input bit bad_last);
    logic hs;
    int g;
    for (int i = 0; i < len; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 8'($urandom);
      s_axis_tlast  = bad_last ? (i == 0 && len > 1) : (i == len - 1);
      buf_q.push_back('{addr: 10'(i), data: s_axis_tdata});
      g = 0;
      do begin
        @(negedge clk) hs = s_axis_tready;
        @(posedge clk);
        #1 g++;
      end while (!hs && g < 20);
      if (!hs) check("stream_handshake_timeout", 0, 1);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int g;
    g = 0;
    while (busy && g < budget) begin
      @(posedge clk);
      #1 g++;
    end
    if (busy) check("wait_idle_timeout", 1, 0);
  endtask

  task automatic wait_eng_start(input int budget);
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!eng_start && g < budget);
    if (!eng_start) check("eng_start_timeout", 0, 1);
  endtask

  task automatic run_pass(input int len, input int nn, input bit model,
                          input bit stall, input bit bad_last);
    int base;
    int g;
    logic [7:0] d;
    cfg_write(8'h01, 32'(len));
    cfg_write(8'h02, 32'(nn));
    if (model) begin
      for (int b = 0; b < (nn + 7) / 8; b++) begin
        d = '0;
        for (int k = 0; k < 8; k++) if (b * 8 + k < nn) d[k] = res[b * 8 + k];
        out_q.push_back('{data: d, last: (b == (nn + 7) / 8 - 1)});
      end
    end
    base = irq_cnt;
    exp_neu = 0;
    if (stall) m_axis_tready = 1'b0;
    cfg_write(8'h00, 32'h1);
    check("start_busy", busy, 1);
    check("start_err", err, 0);
    stream(len, bad_last);
    if (stall) begin
      g = 0;
      while (!m_axis_tvalid && g < 200) begin
        @(posedge clk);
        #1 g++;
      end
      if (!m_axis_tvalid || out_q.size() == 0) check("stall_tvalid_timeout", 0, 1);
      else begin
        repeat (5) begin
          @(posedge clk);
          #1 check("stall_hold", {m_axis_tvalid, m_axis_tdata, m_axis_tlast},
                   {1'b1, out_q[0].data, out_q[0].last});
        end
      end
      m_axis_tready = 1'b1;
    end
    wait_idle(5000);
    check("pass_irq_count", irq_cnt - base, 1);
    check("pass_err", err, bad_last);
    check("pass_out_left", out_q.size(), 0);
    check("pass_buf_left", buf_q.size(), 0);
    check("pass_neurons", exp_neu, nn);
    out_q.delete();
    buf_q.delete();
  endtask

  cfg_vec_t vecs [8];

  initial begin
    int base;
    rst = 1'b1;
    cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 256; i++) res[i] = 1'b0;

    vecs[0] = '{len: 4,   nn: 0,   exp_err: 1'b1, exp_busy: 1'b0};
    vecs[1] = '{len: 0,   nn: 10,  exp_err: 1'b1, exp_busy: 1'b0};
    vecs[2] = '{len: 785, nn: 10,  exp_err: 1'b1, exp_busy: 1'b0};
    vecs[3] = '{len: 4,   nn: 257, exp_err: 1'b1, exp_busy: 1'b0};
    vecs[4] = '{len: 784, nn: 256, exp_err: 1'b0, exp_busy: 1'b1};
    vecs[5] = '{len: 1,   nn: 1,   exp_err: 1'b0, exp_busy: 1'b1};
    vecs[6] = '{len: 786, nn: 1,   exp_err: 1'b1, exp_busy: 1'b0};
    vecs[7] = '{len: 4,   nn: 0,   exp_err: 1'b1, exp_busy: 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {s_axis_tready, buf_we, buf_waddr, buf_wdata, eng_start, eng_neuron,
                            m_axis_tdata, m_axis_tvalid, m_axis_tlast, busy, irq_done, err}, 0);
    rst = 1'b0;

    // Reset in the middle of a load
    cfg_write(8'h01, 32'd4);
    cfg_write(8'h00, 32'h1);
    check("midload_busy", busy, 1);
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 8'hA5;
    buf_q.push_back('{addr: 10'd0, data: 8'hA5});
    @(posedge clk);
    #1 s_axis_tdata = 8'h5A;
    buf_q.push_back('{addr: 10'd1, data: 8'h5A});
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midload_reset_outputs", {s_axis_tready, buf_we, buf_waddr, buf_wdata, eng_start, eng_neuron,
                                    m_axis_tdata, m_axis_tvalid, m_axis_tlast, busy, irq_done, err}, 0);
    check("midload_img_len", dut.img_len, 784);
    check("midload_buf_writes", buf_q.size(), 0);
    s_axis_tvalid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    buf_q.delete();

    // Nominal pass with fixed expected bytes
    res[0] = 1; res[1] = 0; res[2] = 1; res[3] = 1; res[4] = 0;
    res[5] = 0; res[6] = 0; res[7] = 1; res[8] = 1; res[9] = 1;
    out_q.push_back('{data: 8'h8D, last: 1'b0});
    out_q.push_back('{data: 8'h03, last: 1'b1});
    run_pass(4, 10, 1'b0, 1'b0, 1'b0);

    // Backpressure in SEND
    for (int i = 0; i < 256; i++) res[i] = 1'($urandom_range(0, 1));
    run_pass(4, 10, 1'b1, 1'b1, 1'b0);

    // Configuration vectors
    for (int i = 0; i < 8; i++) begin
      cfg_write(8'h01, 32'(vecs[i].len));
      cfg_write(8'h02, 32'(vecs[i].nn));
      cfg_write(8'h00, 32'h1);
      check($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
      @(posedge clk);
      #1 check($sformatf("vec%0d_tready", i), s_axis_tready, vecs[i].exp_busy);
      if (vecs[i].exp_busy) begin
        cfg_write(8'h00, 32'h2);
        check($sformatf("vec%0d_abort_busy", i), busy, 0);
        check($sformatf("vec%0d_abort_err", i), err, 0);
      end
    end

    // Start and abort in the same write: abort wins
    cfg_write(8'h02, 32'd10);
    cfg_write(8'h01, 32'd4);
    cfg_write(8'h00, 32'h3);
    check("start_abort_busy", busy, 0);
    check("start_abort_err", err, 1);

    // Abort during WAIT
    eng_en = 1'b0;
    cfg_write(8'h00, 32'h1);
    check("abort_start_err", err, 0);
    stream(4, 1'b0);
    wait_eng_start(50);
    @(posedge clk);
    #1 base = irq_cnt;
    cfg_write(8'h00, 32'h2);
    check("abort_busy", busy, 0);
    repeat (4) begin
      @(negedge clk);
      check("abort_eng_start", {eng_start, eng_neuron}, 0);
    end
    check("abort_irq", irq_cnt - base, 0);
    check("abort_err", err, 0);
    eng_en = 1'b1;
    buf_q.delete();

    // A bad start sets err; the next good pass clears it
    cfg_write(8'h02, 32'd0);
    cfg_write(8'h00, 32'h1);
    check("bad_start_err", err, 1);
    for (int i = 0; i < 256; i++) res[i] = 1'($urandom_range(0, 1));
    run_pass(8, 8, 1'b1, 1'b0, 1'b0);
    run_pass(3, 9, 1'b1, 1'b0, 1'b0);
    run_pass(2, 17, 1'b1, 1'b0, 1'b0);
    run_pass(5, 3, 1'b1, 1'b0, 1'b1);

`ifdef BNN_SEQ_TIMEOUT_EN
    begin
      int n;
      eng_en = 1'b0;
      cfg_write(8'h01, 32'd2);
      cfg_write(8'h02, 32'd4);
      base = irq_cnt;
      cfg_write(8'h00, 32'h1);
      stream(2, 1'b0);
      wait_eng_start(50);
      n = 0;
      do begin
        @(posedge clk);
        #1 n++;
      end while (busy && n < 100);
      check("timeout_cycles", n, 17);
      check("timeout_err", err, 1);
      check("timeout_irq", irq_cnt - base, 0);
      eng_en = 1'b1;
      buf_q.delete();
    end
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
